// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ command requesters.
// Runs SETUP/ACCESS phases, decodes psel from the address MSBs and returns one response pulse.
module apb_req_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_SLAVE  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int SEL_BITS   = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic [NUM_SLAVE-1:0]            psel,
    output logic [ADDR_WIDTH-1:0]           paddr,
    output logic                            pwrite,
    output logic [DATA_WIDTH-1:0]           pwdata,
    output logic                            penable,
    input  logic [DATA_WIDTH-1:0]           prdata,
    input  logic                            pready,
    input  logic                            pslverr
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_SLAVE-1:0]   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic                   pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;

    logic                   gnt_any;
    logic [PTR_W-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]     gnt_oh;
    logic [ADDR_WIDTH-1:0]  gnt_addr;
    logic [DATA_WIDTH-1:0]  gnt_wdata;
    logic                   gnt_write;
    logic [SEL_BITS-1:0]    gnt_sidx;
    logic                   dec_err;
    logic [NUM_SLAVE-1:0]   dec_sel;
    logic [NUM_REQ-1:0]     rsp_oh;

    // Scan from ptr+1 with wrap; iterating from the farthest offset down lets the nearest valid win.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((((int'(ptr_q) + i) % NUM_REQ) == j) && req_valid[j]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PTR_W'(j);
                end
            end
        end
    end

    always_comb begin
        gnt_oh    = '0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        gnt_write = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt_any && (int'(gnt_idx) == j)) begin
                gnt_oh[j] = 1'b1;
                gnt_addr  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_wdata = req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
                gnt_write = req_write[j];
            end
        end
    end

    always_comb begin
        gnt_sidx = gnt_addr[ADDR_WIDTH-1 -: SEL_BITS];
        dec_err  = (int'(gnt_sidx) >= NUM_SLAVE);
        dec_sel  = '0;
        for (int s = 0; s < NUM_SLAVE; s++) begin
            dec_sel[s] = (int'(gnt_sidx) == s);
        end
    end

    always_comb begin
        rsp_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            rsp_oh[j] = (int'(gnt_q) == j);
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    ptr_d    = gnt_idx;
                    gnt_d    = gnt_idx;
                    paddr_d  = gnt_addr;
                    pwrite_d = gnt_write;
                    pwdata_d = gnt_wdata;
                    if (dec_err) begin
                        // Unmapped slave: answer immediately without touching the bus.
                        state_d     = ST_RESP;
                        rsp_valid_d = gnt_oh;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = ST_SETUP;
                        psel_d    = dec_sel;
                        penable_d = 1'b0;
                    end
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (pready) begin
                    state_d     = ST_RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = rsp_oh;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = ST_RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = rsp_oh;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            cnt_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The accept pulse is the only combinational output; it is held low while in reset.
    assign req_ready = ((state_q == ST_IDLE) && !rst) ? gnt_oh : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a default instance plus a NUM_SLAVE=3 instance for decode errors.
module tb_apb_req_arbiter;

    logic        clk;
    logic        rst;

    logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [15:0] rsp_rdata, pwdata, prdata;
    logic        rsp_err, pwrite, penable, pready, pslverr;
    logic [3:0]  psel;
    logic [7:0]  paddr;

    logic [1:0]  req_valid_3, req_write_3, req_ready_3, rsp_valid_3;
    logic [15:0] req_addr_3;
    logic [31:0] req_wdata_3;
    logic [15:0] rsp_rdata_3, pwdata_3, prdata_3;
    logic        rsp_err_3, pwrite_3, penable_3, pready_3, pslverr_3;
    logic [2:0]  psel_3;
    logic [7:0]  paddr_3;

    int errors = 0;
    int checks = 0;

    apb_req_arbiter #(.NUM_REQ(2), .NUM_SLAVE(4), .ADDR_WIDTH(8), .DATA_WIDTH(16),
                      .SEL_BITS(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_req_arbiter #(.NUM_REQ(2), .NUM_SLAVE(3), .ADDR_WIDTH(8), .DATA_WIDTH(16),
                      .SEL_BITS(2), .TIMEOUT(16)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_3), .req_write(req_write_3), .req_addr(req_addr_3), .req_wdata(req_wdata_3),
        .req_ready(req_ready_3), .rsp_valid(rsp_valid_3), .rsp_rdata(rsp_rdata_3), .rsp_err(rsp_err_3),
        .psel(psel_3), .paddr(paddr_3), .pwrite(pwrite_3), .pwdata(pwdata_3), .penable(penable_3),
        .prdata(prdata_3), .pready(pready_3), .pslverr(pslverr_3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 2'b11; req_write = 2'b00; req_addr = 16'h0000; req_wdata = 32'h0;
        prdata = 16'h0; pready = 1'b0; pslverr = 1'b0;
        req_valid_3 = 2'b11; req_write_3 = 2'b00; req_addr_3 = 16'h0000; req_wdata_3 = 32'h0;
        prdata_3 = 16'h7777; pready_3 = 1'b1; pslverr_3 = 1'b0;
        tick();
        tick();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        checks++; if (psel !== 4'b0000) begin errors++; $display("FAIL reset_psel got %b exp 0000", psel); end
        checks++; if (penable !== 1'b0) begin errors++; $display("FAIL reset_penable got %b exp 0", penable); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
        checks++; if (paddr !== 8'h00 || pwdata !== 16'h0 || pwrite !== 1'b0) begin
            errors++; $display("FAIL reset_bus got paddr=%h pwdata=%h pwrite=%b exp 0", paddr, pwdata, pwrite); end
        checks++; if (rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got rdata=%h err=%b exp 0", rsp_rdata, rsp_err); end
        checks++; if (req_ready_3 !== 2'b00 || psel_3 !== 3'b000) begin
            errors++; $display("FAIL reset_dut3 got ready=%b psel=%b exp 0", req_ready_3, psel_3); end
        rst = 1'b0;
        req_valid = 2'b00;
        req_valid_3 = 2'b00;
    endtask

    task automatic test_single_read;
        req_valid = 2'b01; req_write = 2'b00; req_addr = 16'h0045;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL read_accept got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00; pready = 1'b1; prdata = 16'hBEEF;
        #1;
        checks++; if (psel !== 4'b0010 || penable !== 1'b0) begin
            errors++; $display("FAIL read_setup got psel=%b penable=%b exp 0010/0", psel, penable); end
        checks++; if (paddr !== 8'h45 || pwrite !== 1'b0) begin
            errors++; $display("FAIL read_setup_addr got %h/%b exp 45/0", paddr, pwrite); end
        checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL read_setup_hs got ready=%b rsp=%b exp 00/00", req_ready, rsp_valid); end
        tick();
        checks++; if (psel !== 4'b0010 || penable !== 1'b1) begin
            errors++; $display("FAIL read_access got psel=%b penable=%b exp 0010/1", psel, penable); end
        tick();
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL read_rsp_valid got %b exp 01", rsp_valid); end
        checks++; if (rsp_rdata !== 16'hBEEF || rsp_err !== 1'b0) begin
            errors++; $display("FAIL read_rsp_data got %h/%b exp beef/0", rsp_rdata, rsp_err); end
        checks++; if (psel !== 4'b0000 || penable !== 1'b0) begin
            errors++; $display("FAIL read_resp_bus got psel=%b penable=%b exp 0", psel, penable); end
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL read_rsp_once got %b exp 00", rsp_valid); end
        pready = 1'b0; prdata = 16'h0;
    endtask

    task automatic test_round_robin_writes;
        logic [1:0]  exp_oh;
        logic [3:0]  exp_sel;
        logic [7:0]  exp_addr;
        logic [15:0] exp_wdata;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 2'b11; req_write = 2'b11; req_addr = 16'hA310; req_wdata = 32'h2222_1111;
        pready = 1'b1; prdata = 16'hDEAD;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_oh    = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_sel   = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            exp_addr  = (k % 2 == 0) ? 8'h10 : 8'hA3;
            exp_wdata = (k % 2 == 0) ? 16'h1111 : 16'h2222;
            checks++; if (req_ready !== exp_oh) begin
                errors++; $display("FAIL rr_grant[%0d] got %b exp %b", k, req_ready, exp_oh); end
            checks++; if (psel !== 4'b0000) begin
                errors++; $display("FAIL rr_idle_gap[%0d] got psel=%b exp 0000", k, psel); end
            tick();
            checks++; if (psel !== exp_sel || paddr !== exp_addr || pwrite !== 1'b1) begin
                errors++; $display("FAIL rr_setup[%0d] got psel=%b paddr=%h pwrite=%b exp %b/%h/1", k, psel, paddr, pwrite, exp_sel, exp_addr); end
            checks++; if (pwdata !== exp_wdata) begin
                errors++; $display("FAIL rr_pwdata[%0d] got %h exp %h", k, pwdata, exp_wdata); end
            checks++; if (req_ready !== 2'b00) begin
                errors++; $display("FAIL rr_no_grant_busy[%0d] got %b exp 00", k, req_ready); end
            tick();
            checks++; if (penable !== 1'b1 || psel !== exp_sel) begin
                errors++; $display("FAIL rr_access[%0d] got penable=%b psel=%b exp 1/%b", k, penable, psel, exp_sel); end
            tick();
            checks++; if (rsp_valid !== exp_oh || rsp_err !== 1'b0 || rsp_rdata !== 16'h0) begin
                errors++; $display("FAIL rr_rsp[%0d] got v=%b err=%b rdata=%h exp %b/0/0000", k, rsp_valid, rsp_err, rsp_rdata, exp_oh); end
            if (k == 3) req_valid = 2'b00;
            tick();
        end
        pready = 1'b0; prdata = 16'h0; req_write = 2'b00;
    endtask

    task automatic test_wait_states;
        int pen_cnt = 0;
        int rsp_cnt = 0;
        int rsp_cyc = -1;
        logic [1:0]  rv_seen = 2'b00;
        logic        err_seen = 1'b0;
        logic [15:0] rd_seen = 16'h0;
        req_valid = 2'b01; req_write = 2'b00; req_addr = 16'h00E4; pready = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ws_accept got %b exp 01", req_ready); end
        for (int c = 1; c <= 9; c++) begin
            tick();
            req_valid = 2'b00;
            pready  = (c == 5);
            pslverr = (c == 5);
            prdata  = (c == 5) ? 16'h1234 : 16'h0000;
            #1;
            if (penable) begin
                pen_cnt++;
                checks++; if (paddr !== 8'hE4 || psel !== 4'b1000) begin
                    errors++; $display("FAIL ws_addr_stable[c%0d] got paddr=%h psel=%b exp e4/1000", c, paddr, psel); end
            end
            if (rsp_valid !== 2'b00) begin
                rsp_cnt++; rsp_cyc = c; rv_seen = rsp_valid; err_seen = rsp_err; rd_seen = rsp_rdata;
            end
        end
        checks++; if (pen_cnt != 4) begin errors++; $display("FAIL ws_penable_cycles got %0d exp 4", pen_cnt); end
        checks++; if (rsp_cnt != 1 || rsp_cyc != 6) begin
            errors++; $display("FAIL ws_rsp_count got %0d at cycle %0d exp 1 at 6", rsp_cnt, rsp_cyc); end
        checks++; if (rv_seen !== 2'b01 || err_seen !== 1'b1 || rd_seen !== 16'h1234) begin
            errors++; $display("FAIL ws_rsp got v=%b err=%b rdata=%h exp 01/1/1234", rv_seen, err_seen, rd_seen); end
        pready = 1'b0; pslverr = 1'b0; prdata = 16'h0;
    endtask

    task automatic test_decode_error;
        req_valid_3 = 2'b01; req_write_3 = 2'b00; req_addr_3 = 16'h0080; req_wdata_3 = 32'h0;
        pready_3 = 1'b1; prdata_3 = 16'h7777;
        #1;
        checks++; if (req_ready_3 !== 2'b01) begin errors++; $display("FAIL dec_ok_accept got %b exp 01", req_ready_3); end
        tick();
        req_valid_3 = 2'b00;
        #1;
        checks++; if (psel_3 !== 3'b100 || paddr_3 !== 8'h80 || pwrite_3 !== 1'b0 || pwdata_3 !== 16'h0) begin
            errors++; $display("FAIL dec_ok_setup got psel=%b paddr=%h pwrite=%b pwdata=%h exp 100/80/0/0000", psel_3, paddr_3, pwrite_3, pwdata_3); end
        tick();
        tick();
        checks++; if (rsp_valid_3 !== 2'b01 || rsp_rdata_3 !== 16'h7777 || rsp_err_3 !== 1'b0) begin
            errors++; $display("FAIL dec_ok_rsp got v=%b rdata=%h err=%b exp 01/7777/0", rsp_valid_3, rsp_rdata_3, rsp_err_3); end
        tick();
        req_valid_3 = 2'b10; req_addr_3 = 16'hC080;
        #1;
        checks++; if (req_ready_3 !== 2'b10) begin errors++; $display("FAIL dec_err_accept got %b exp 10", req_ready_3); end
        tick();
        req_valid_3 = 2'b00;
        #1;
        checks++; if (rsp_valid_3 !== 2'b10 || rsp_err_3 !== 1'b1 || rsp_rdata_3 !== 16'h0) begin
            errors++; $display("FAIL dec_err_rsp got v=%b err=%b rdata=%h exp 10/1/0000", rsp_valid_3, rsp_err_3, rsp_rdata_3); end
        checks++; if (psel_3 !== 3'b000 || penable_3 !== 1'b0) begin
            errors++; $display("FAIL dec_err_no_bus got psel=%b penable=%b exp 000/0", psel_3, penable_3); end
        tick();
        checks++; if (rsp_valid_3 !== 2'b00 || psel_3 !== 3'b000 || penable_3 !== 1'b0) begin
            errors++; $display("FAIL dec_err_after got v=%b psel=%b penable=%b exp 0", rsp_valid_3, psel_3, penable_3); end
    endtask

    task automatic test_timeout;
        int pen_cnt = 0;
        int rsp_cnt = 0;
        int rsp_cyc = -1;
        logic [1:0]  rv_seen = 2'b00;
        logic        err_seen = 1'b0;
        logic [15:0] rd_seen = 16'hFFFF;
        req_valid = 2'b10; req_write = 2'b00; req_addr = 16'h2200; pready = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL to_accept got %b exp 10", req_ready); end
        for (int c = 1; c <= 20; c++) begin
            tick();
            req_valid = 2'b00;
            if (penable) pen_cnt++;
            if (rsp_valid !== 2'b00) begin
                rsp_cnt++; rsp_cyc = c; rv_seen = rsp_valid; err_seen = rsp_err; rd_seen = rsp_rdata;
            end
        end
        checks++; if (pen_cnt != 16) begin errors++; $display("FAIL to_penable_cycles got %0d exp 16", pen_cnt); end
        checks++; if (rsp_cnt != 1 || rsp_cyc != 18) begin
            errors++; $display("FAIL to_rsp_count got %0d at cycle %0d exp 1 at 18", rsp_cnt, rsp_cyc); end
        checks++; if (rv_seen !== 2'b10 || err_seen !== 1'b1 || rd_seen !== 16'h0) begin
            errors++; $display("FAIL to_rsp got v=%b err=%b rdata=%h exp 10/1/0000", rv_seen, err_seen, rd_seen); end
        checks++; if (psel !== 4'b0000 || penable !== 1'b0) begin
            errors++; $display("FAIL to_idle_bus got psel=%b penable=%b exp 0", psel, penable); end
    endtask

    task automatic test_reset_mid_transfer;
        req_valid = 2'b01; req_write = 2'b00; req_addr = 16'h0045; pready = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_accept got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        checks++; if (penable !== 1'b1 || psel !== 4'b0010) begin
            errors++; $display("FAIL rm_in_access got penable=%b psel=%b exp 1/0010", penable, psel); end
        rst = 1'b1;
        tick();
        checks++; if (psel !== 4'b0000 || penable !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL rm_after_rst got psel=%b penable=%b rsp=%b exp 0", psel, penable, rsp_valid); end
        rst = 1'b0;
        req_valid = 2'b11; pready = 1'b1; prdata = 16'h5A5A;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_ptr_reset got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00;
        #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_no_stale_rsp got %b exp 00", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_no_early_rsp got %b exp 00", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 16'h5A5A || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rm_new_rsp got v=%b rdata=%h err=%b exp 01/5a5a/0", rsp_valid, rsp_rdata, rsp_err); end
        pready = 1'b0; prdata = 16'h0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin_writes();
        test_wait_states();
        test_decode_error();
        test_timeout();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
